irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Sequential front end for the 4-input priority encoder stage.
- Edge-detects 4 request lines into sticky pending bits and applies a mask.
- Selects the highest-priority unmasked source (bit 3 highest, bit 0 lowest) and presents it to a consumer as irq/irq_id, holding it until acknowledged.
- Clears the serviced pending bit on ack, waits a programmable guard gap, then re-arbitrates.

Parameters:
- GAP_CYCLES, 2, idle cycles after ack before the next arbitration (range 0..15).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  raw request lines, synchronous to clk; a rising edge marks one event.
- mask  input  4  1 = source masked (blocked from selection only).
- ack  input  1  consumer acknowledge; meaningful only while irq=1.
- ovr_clr  input  1  clears all overrun bits.
- irq  output  1  registered; 1 = irq_id valid and awaiting ack.
- irq_id  output  2  registered index of the selected source; 3 is highest priority.
- pending  output  4  registered sticky pending bits.
- overrun  output  4  registered sticky flags; event lost because the bit was already pending.

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - irq=0, irq_id=2'b00, pending=0, overrun=0, req_d=0, gap counter=0, state=IDLE.
  - Reset mid-handshake discards the in-flight interrupt and all pending events.
- Edge detect:
  - rise[i] = req[i] & ~req_d[i]; req_d <= req every cycle.
  - A level held high produces exactly one event.
- Pending update, per bit, in priority order:
  - If rise[i] and pending[i]=1 and no clear this cycle: overrun[i] <= 1 and pending stays 1.
  - If clear[i] and rise[i] in the same cycle: pending[i] stays 1 (set wins, new event) and no overrun.
  - Otherwise: set on rise, clear on clear.
  - clear[i] = (state==REQ) & ack & (irq_id==i).
- Overrun:
  - ovr_clr clears all overrun bits.
  - If ovr_clr and a new overrun coincide, the new overrun wins for that bit.
- Selection: sel = pending & ~mask; the highest set bit of sel wins; used only in IDLE.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if sel != 0, irq_id <= index of highest set bit, irq <= 1, go to REQ. Otherwise stay; irq=0 and irq_id holds its last value.
  - REQ:
    - irq and irq_id are held stable regardless of mask or req changes.
    - A newly arriving higher-priority event does not pre-empt.
    - On ack=1: irq <= 0 and the pending bit is cleared.
    - If GAP_CYCLES=0, go to IDLE; else load counter = GAP_CYCLES - 1 and go to GAP.
  - GAP: irq=0. Decrement the counter; go to IDLE when the counter is 0. Ack is ignored.
  - ack while in IDLE or GAP: ignored, no state change.
- Latency:
  - req sampled high at edge E0 → pending set after E0 → irq=1 after E1 (2 cycles), provided the FSM is in IDLE and the source is unmasked.
  - ack sampled at edge Ea → irq=0 after Ea.
  - Next irq earliest after edge Ea + GAP_CYCLES + 1.
- Masked sources:
  - Pending bits still set and are never lost.
  - They become eligible once the mask drops while the FSM is in IDLE.
- irq_id is driven only from a valid selection; no X output in any state.

Test Plan:
- Reset, then req=4'b0010, mask=0 → pending=0010 after 1 edge; irq=1, irq_id=01 after 2 edges; ack=1 for 1 cycle → irq=0, pending=0000.
- req=4'b1011 rising simultaneously, GAP_CYCLES=2 → services in order 11, 01, 00. Each irq follows the previous ack by exactly 3 cycles; pending goes 1011→0011→0001→0000.
- mask=4'b1000, req[3] and req[0] rise together → irq_id=00 first. After clearing mask=0 in IDLE → irq_id=11; pending[3] is retained throughout.
- While irq_id=01 is awaiting ack, req[1] drops and rises again → overrun=0010, pending[1] stays 1. ovr_clr=1 → overrun=0000.
- req[2] rises in the same cycle ack clears irq_id=10 → pending[2] remains 1, overrun[2]=0, irq_id=10 is re-issued after the gap.
- rst=1 asserted while irq=1 → next cycle irq=0, pending=0, overrun=0; a later ack is ignored.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: edge-detects four request lines into sticky pending bits,
// picks the highest-priority unmasked source and holds it until acknowledged.
module irq_pending_ctrl #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic       ovr_clr,
    output logic       irq,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // The counter holds GAP_CYCLES-1 so that GAP_CYCLES idle cycles elapse after ack.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0] state;
    logic [3:0] req_d;
    logic [3:0] gap_cnt;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] sel;
    logic [3:0] pending_nxt;
    logic [3:0] overrun_nxt;
    logic [1:0] sel_id;

    function automatic logic [1:0] top_index(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clr = '0;
        if (state == ST_REQ && ack)
            clr[irq_id] = 1'b1;
    end

    assign rise   = req & ~req_d;
    assign sel    = pending & ~mask;
    assign sel_id = top_index(sel);

    // A fresh rising edge always wins over a clear, so a coincident event is never dropped.
    assign pending_nxt = rise | (pending & ~clr);
    assign overrun_nxt = (overrun & ~{4{ovr_clr}}) | (rise & pending & ~clr);

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_d   <= '0;
            gap_cnt <= '0;
            pending <= '0;
            overrun <= '0;
            irq     <= 1'b0;
            irq_id  <= 2'd0;
        end else begin
            req_d   <= req;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            case (state)
                ST_IDLE: begin
                    if (|sel) begin
                        irq_id <= sel_id;
                        irq    <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        irq <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: vector table through a scoreboard queue for the
// default gap, plus a short hand sequence on a zero-gap instance.
module tb_irq_pending_ctrl;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic       ovr_clr;
        logic       exp_irq;
        logic [1:0] exp_id;
        logic [3:0] exp_pending;
        logic [3:0] exp_overrun;
    } vec_t;

    typedef struct {
        int         idx;
        logic       irq;
        logic [1:0] id;
        logic [3:0] pending;
        logic [3:0] overrun;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, ack, ovr_clr;
    logic [3:0] req, mask;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending, overrun;

    logic       rst0, ack0;
    logic [3:0] req0;
    logic       irq0;
    logic [1:0] irq_id0;
    logic [3:0] pending0, overrun0;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    irq_pending_ctrl #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack), .ovr_clr(ovr_clr),
        .irq(irq), .irq_id(irq_id), .pending(pending), .overrun(overrun)
    );

    irq_pending_ctrl #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .mask(4'b0000), .ack(ack0), .ovr_clr(1'b0),
        .irq(irq0), .irq_id(irq_id0), .pending(pending0), .overrun(overrun0)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] m, input logic a,
                       input logic oc, input logic ei, input logic [1:0] eid,
                       input logic [3:0] ep, input logic [3:0] eo);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = m; v.ack = a; v.ovr_clr = oc;
        v.exp_irq = ei; v.exp_id = eid; v.exp_pending = ep; v.exp_overrun = eo;
        vecs.push_back(v);
    endtask

    task automatic step0(input logic r, input logic [3:0] rq, input logic a, input string name,
                         input logic ei, input logic [1:0] eid, input logic [3:0] ep);
        @(negedge clk);
        rst0 = r; req0 = rq; ack0 = a;
        @(posedge clk);
        #1;
        check({name, ".irq"}, {3'b000, irq0}, {3'b000, ei});
        check({name, ".id"}, {2'b00, irq_id0}, {2'b00, eid});
        check({name, ".pending"}, pending0, ep);
        check({name, ".overrun"}, overrun0, 4'b0000);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; req = '0; mask = '0; ack = 1'b0; ovr_clr = 1'b0;
        rst0 = 1'b1; req0 = '0; ack0 = 1'b0;

        //   rst req     mask    ack oc  irq id     pending overrun
        // reset, single source, ack, guard gap
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0000); // 0
        add(0, 4'b0010, 4'b0000, 0, 0, 0, 2'd0, 4'b0010, 4'b0000); // 1
        add(0, 4'b0010, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 4'b0000); // 2
        add(0, 4'b0010, 4'b0000, 1, 0, 0, 2'd1, 4'b0000, 4'b0000); // 3
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1, 4'b0000, 4'b0000); // 4
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1, 4'b0000, 4'b0000); // 5
        // three simultaneous sources serviced 3, 1, 0; each irq 3 edges after its ack
        add(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd1, 4'b1011, 4'b0000); // 6
        add(0, 4'b1011, 4'b0000, 0, 0, 1, 2'd3, 4'b1011, 4'b0000); // 7
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 2'd3, 4'b0011, 4'b0000); // 8
        add(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd3, 4'b0011, 4'b0000); // 9
        add(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd3, 4'b0011, 4'b0000); // 10
        add(0, 4'b1011, 4'b0000, 0, 0, 1, 2'd1, 4'b0011, 4'b0000); // 11
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 2'd1, 4'b0001, 4'b0000); // 12
        add(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd1, 4'b0001, 4'b0000); // 13
        add(0, 4'b1011, 4'b0000, 0, 0, 0, 2'd1, 4'b0001, 4'b0000); // 14
        add(0, 4'b1011, 4'b0000, 0, 0, 1, 2'd0, 4'b0001, 4'b0000); // 15
        add(0, 4'b1011, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000); // 16
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0000); // 17
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0000); // 18
        // masked source 3 retained, served once mask drops in IDLE
        add(0, 4'b1001, 4'b1000, 0, 0, 0, 2'd0, 4'b1001, 4'b0000); // 19
        add(0, 4'b1001, 4'b1000, 0, 0, 1, 2'd0, 4'b1001, 4'b0000); // 20
        add(0, 4'b1001, 4'b1000, 1, 0, 0, 2'd0, 4'b1000, 4'b0000); // 21
        add(0, 4'b1001, 4'b1000, 0, 0, 0, 2'd0, 4'b1000, 4'b0000); // 22
        add(0, 4'b1001, 4'b1000, 0, 0, 0, 2'd0, 4'b1000, 4'b0000); // 23
        add(0, 4'b1001, 4'b1000, 0, 0, 0, 2'd0, 4'b1000, 4'b0000); // 24
        add(0, 4'b1001, 4'b0000, 0, 0, 1, 2'd3, 4'b1000, 4'b0000); // 25
        add(0, 4'b1001, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0000); // 26
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 4'b0000); // 27
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 4'b0000); // 28
        // overrun on re-rise while pending, ovr_clr, and ovr_clr vs new overrun
        add(0, 4'b0010, 4'b0000, 0, 0, 0, 2'd3, 4'b0010, 4'b0000); // 29
        add(0, 4'b0010, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 4'b0000); // 30
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 4'b0000); // 31
        add(0, 4'b0010, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 4'b0010); // 32
        add(0, 4'b0010, 4'b0000, 0, 1, 1, 2'd1, 4'b0010, 4'b0000); // 33
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 4'b0000); // 34
        add(0, 4'b0010, 4'b0000, 0, 1, 1, 2'd1, 4'b0010, 4'b0010); // 35
        add(0, 4'b0010, 4'b0000, 0, 1, 1, 2'd1, 4'b0010, 4'b0000); // 36
        add(0, 4'b0010, 4'b0000, 1, 0, 0, 2'd1, 4'b0000, 4'b0000); // 37
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1, 4'b0000, 4'b0000); // 38
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 2'd1, 4'b0000, 4'b0000); // 39
        // rise coinciding with the clearing ack keeps the bit pending, no overrun
        add(0, 4'b0100, 4'b0000, 0, 0, 0, 2'd1, 4'b0100, 4'b0000); // 40
        add(0, 4'b0100, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0000); // 41
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0000); // 42
        add(0, 4'b0100, 4'b0000, 1, 0, 0, 2'd2, 4'b0100, 4'b0000); // 43
        add(0, 4'b0100, 4'b0000, 0, 0, 0, 2'd2, 4'b0100, 4'b0000); // 44
        add(0, 4'b0100, 4'b0000, 0, 0, 0, 2'd2, 4'b0100, 4'b0000); // 45
        add(0, 4'b0100, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 4'b0000); // 46
        // higher priority arrival and mask change do not disturb a held irq
        add(0, 4'b1100, 4'b0000, 0, 0, 1, 2'd2, 4'b1100, 4'b0000); // 47
        add(0, 4'b1100, 4'b1111, 0, 0, 1, 2'd2, 4'b1100, 4'b0000); // 48
        // reset mid-handshake, later acks ignored
        add(1, 4'b1100, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0000); // 49
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000); // 50
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0000); // 51

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req; mask = vecs[i].mask;
            ack = vecs[i].ack; ovr_clr = vecs[i].ovr_clr;
            e.idx = i; e.irq = vecs[i].exp_irq; e.id = vecs[i].exp_id;
            e.pending = vecs[i].exp_pending; e.overrun = vecs[i].exp_overrun;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d.irq", e.idx), {3'b000, irq}, {3'b000, e.irq});
                check($sformatf("v%0d.id", e.idx), {2'b00, irq_id}, {2'b00, e.id});
                check($sformatf("v%0d.pending", e.idx), pending, e.pending);
                check($sformatf("v%0d.overrun", e.idx), overrun, e.overrun);
            end
        end

        // Zero-gap instance: the next irq follows one edge after the ack.
        step0(1, 4'b0000, 0, "g0_reset", 0, 2'd0, 4'b0000);
        step0(0, 4'b0011, 0, "g0_rise",  0, 2'd0, 4'b0011);
        step0(0, 4'b0011, 0, "g0_irq1",  1, 2'd1, 4'b0011);
        step0(0, 4'b0011, 1, "g0_ack",   0, 2'd1, 4'b0001);
        step0(0, 4'b0011, 0, "g0_irq0",  1, 2'd0, 4'b0001);
        step0(0, 4'b0011, 1, "g0_ack2",  0, 2'd0, 4'b0000);
        step0(0, 4'b0011, 0, "g0_idle",  0, 2'd0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
